// File: rtl/uart_rx_pkg.sv
// Shared baud divisor constants (clk cycles per bit at 12 MHz) and a helper
// for the half-bit offset used by the receiver.
package uart_rx_pkg;

   localparam int B115200 = 104;
   localparam int B57600  = 208;
   localparam int B38400  = 313;
   localparam int B19200  = 625;
   localparam int B9600   = 1250;
   localparam int B4800   = 2500;
   localparam int B2400   = 5000;
   localparam int B1200   = 10000;
   localparam int B600    = 20000;
   localparam int B300    = 40000;

   localparam int DATA_BITS = 8;

   function automatic int half_period(input int baud);
      return baud >> 1;
   endfunction

endpackage

// File: rtl/baudgen_rx.sv
// Receive-side baud tick generator: tick HALF cycles after load, then every
// BAUDRATE cycles (down-counter with terminal-count compare).
module baudgen_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUDRATE = B115200
) (
   input  logic clk,
   input  logic rstn,
   input  logic load,
   output logic clk_out
);

   localparam int W = $clog2(BAUDRATE);
   localparam logic [W-1:0] RELOAD_FULL = W'(BAUDRATE - 1);
   localparam logic [W-1:0] RELOAD_HALF = W'(half_period(BAUDRATE) - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD_HALF;
      end else if (cnt == '0) begin
         cnt <= RELOAD_FULL;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign clk_out = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling of a synchronized rx line.
// Define UART_RX_FERR_EN to add the ferr framing-error pulse output.
//
//   state | meaning
//   IDLE  | line idle, waiting for rxs low (start edge)
//   START | waiting for mid start bit; high there means glitch
//   DATA  | sampling 8 data bits at mid-bit
//   STOP  | sampling stop bit; low means framing error
//   BRK   | line held low after framing error, wait for high
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int BAUDRATE = B115200
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx,
   output logic       rcv,
`ifdef UART_RX_FERR_EN
   output logic       ferr,
`endif
   output logic [7:0] data
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } state_t;

   state_t                 state;
   logic [1:0]             sync_q;
   logic                   rxs;
   logic                   tick;
   logic                   load;
   logic [DATA_BITS-1:0]   shreg;
   logic [2:0]             idx;

   // rx is asynchronous to clk; both flops reset to the idle level
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rxs  = sync_q[1];
   assign load = (state == IDLE) && !rxs;

   baudgen_rx #(
      .BAUDRATE (BAUDRATE)
   ) u_baudgen (
      .clk     (clk),
      .rstn    (rstn),
      .load    (load),
      .clk_out (tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         shreg <= '0;
         idx   <= '0;
         data  <= '0;
         rcv   <= 1'b0;
`ifdef UART_RX_FERR_EN
         ferr  <= 1'b0;
`endif
      end else begin
         rcv <= 1'b0;
`ifdef UART_RX_FERR_EN
         ferr <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     idx   <= '0;
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  shreg <= {rxs, shreg[DATA_BITS-1:1]};
                  idx   <= idx + 3'd1;
                  if (idx == 3'd7) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (rxs) begin
                     data  <= shreg;
                     rcv   <= 1'b1;
                     state <= IDLE;
                  end else begin
`ifdef UART_RX_FERR_EN
                     ferr  <= 1'b1;
`endif
                     state <= BRK;
                  end
               end
            end
            BRK: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
